lsu_split_unit: RTL
===================

// Module: lsu_split_unit
// PURPOSE
// - Next-generation load/store unit: sits between the RV32 core's memory stage and the data-memory port.
// - Bus width is parametrised (32/64 bit).
// - Misaligned accesses are split into two bus beats, or flagged as an exception.
// - Handles B/H/W/BU/HU loads and B/H/W stores.
// - Stalls the pipeline via lsu_stall_req until the access completes.
// PARAMETERS
// - ADDR_W          32  byte-address width
// - BUS_W           32  data-memory bus width; 32 or 64. BYTES = BUS_W/8, OFF_W = $clog2(BYTES)
// - MISALIGN_SPLIT  1   1: split boundary-crossing accesses; 0: raise lsu_misalign, no bus access
// PORTS
// - clk             in   1         clock
// - rstn            in   1         reset; asynchronous, active-low
// - lsu_req         in   1         core access request; held stable while lsu_stall_req=1
// - lsu_we          in   1         1 = store
// - lsu_size        in   3         LDST_B/H/W/BU/HU code
// - lsu_addr        in   ADDR_W    byte address
// - lsu_wdata       in   32        store data, LSB-justified
// - lsu_rdata       out  32        load result, extended; valid in DONE cycle
// - lsu_stall_req   out  1         freeze pipeline
// - lsu_misalign    out  1         misaligned access with MISALIGN_SPLIT=0 (combinational)
// - mem_req         out  1         bus request; held until mem_gnt
// - mem_we          out  1         bus write
// - mem_addr        out  ADDR_W    bus address, BYTES-aligned (low OFF_W bits = 0)
// - mem_be          out  BYTES     byte enables
// - mem_wdata       out  BUS_W     lane-shifted store data
// - mem_gnt         in   1         request accepted this cycle
// - mem_rvalid      in   1         response (read data / write ack), >=1 cycle after gnt
// - mem_rdata       in   BUS_W     read data
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; beat counter 0; assembly register 0.
// - FSM states:
//   - IDLE: on lsu_req && !misalign_err, latch addr/size/we/wdata, compute beats (1 or 2), go REQ.
//   - REQ: mem_req=1; on mem_gnt go RSP.
//   - RSP: wait mem_rvalid; on rvalid with a beat remaining go REQ (beat 1), else go DONE.
//   - DONE: one cycle; lsu_rdata valid; go IDLE unconditionally. A lsu_req seen in DONE is the finished access and is ignored.
// - lsu_stall_req = (IDLE && lsu_req && !lsu_misalign) || REQ || RSP; 0 in DONE.
// - Minimum latency, aligned access with gnt in the first REQ cycle and rvalid the next cycle: 4 cycles, IDLE->REQ->RSP->DONE.
// - Size codes: B=0, H=1, W=2, BU=4, HU=5; nbytes = 1/2/4. Codes 3/6/7 are treated as W. A store ignores the U bit.
// - Misalignment and splitting, with off = addr[OFF_W-1:0]:
//   - cross = off + nbytes > BYTES.
//   - Split=0: cross || (addr % nbytes != 0) raises lsu_misalign in IDLE with lsu_req. No bus activity; stall=0.
//   - Split=1: only cross causes a split.
//   - Beat 0: address = aligned addr, bytes off..BYTES-1.
//   - Beat 1: address = aligned addr + BYTES (wraps mod 2^ADDR_W), bytes 0..(off+nbytes-BYTES-1).
//   - Non-crossing unaligned accesses are single-beat.
// - Stores: mem_wdata = (wdata << 8*off) on beat 0, (wdata >> 8*(BYTES-off)) on beat 1. Disabled lanes are 0. mem_be matches.
// - Loads: assemble bytes from beat 0 and beat 1 into the assembly register, then sign-extend (B/H) or zero-extend (BU/HU).
// - mem_addr/we/be/wdata are stable while mem_req=1 and are 0 when mem_req=0.
// - mem_rvalid outside RSP is ignored, including late responses after reset.
// - Async reset in any state: immediate return to IDLE, mem_req and stall drop; an in-flight beat is abandoned.
// STRUCTURE
// - lsu_pkg: LDST_* size localparams, state_t enum {IDLE,REQ,RSP,DONE}, functions size_bytes() and is_signed().
// - Sub-module lsu_lane_align (combinational):
//   - store shift and byte enables per beat;
//   - load byte extraction and merge with extension.
// - FSM, latch registers and beat counter stay in the top.
// TESTING (memory model: gnt same cycle, rvalid +1 cycle unless stated; BUS_W=32)
// 1. Stores then loads:
//    - SB 0x00 0x111111AA, SB 0x01 0x222222CC, SH 0x02 0x3333BBBB, SW 0x04 0x1111FAFB -> be 0001,0010,1100,1111; word0=0xBBBBCCAA.
//    - Then LHU 0x00 -> 0x0000CCAA; LB 0x05 -> 0xFFFFFFFA.
// 2. Split load: memory from test 1, LW 0x03 -> beats at 0x00 then 0x04, lsu_rdata=0x11FAFBBB; stall high exactly 5 cycles.
// 3. Split store: SW 0x06 0xDEADBEEF -> beat0 addr 0x04 be 1100 wdata 0xBEEF0000; beat1 addr 0x08 be 0011 wdata 0x0000DEAD.
// 4. MISALIGN_SPLIT=0: LH 0x01 -> lsu_misalign=1 same cycle, stall=0, mem_req never asserts.
//    BUS_W=64: LW 0x04 -> single beat, be 0xF0.
// 5. mem_gnt withheld 3 cycles -> mem_req and payload stable, stall held, completes 3 cycles later.
//    Back-to-back lsu_req: the DONE cycle does not restart the access.
// 6. rstn low during RSP -> all outputs 0 immediately; a later mem_rvalid is ignored; the next access completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store split unit.
// - LDST_* : access size codes driven by the core on lsu_size.
// - state_t: access sequencer states.
// - size_bytes(): number of bytes touched by a size code.
// - is_signed(): whether a load result is sign-extended.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_t;

  // Unused codes (3/6/7) behave as a word access.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: return 3'd1;
      LDST_H, LDST_HU: return 3'd2;
      default:         return 3'd4;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for one bus beat.
// Ports:
// - beat     : 0 = first beat (lanes off..BYTES-1), 1 = second beat of a split
// - off      : byte offset of the access inside a bus word
// - size     : LDST_* size code
// - st_data  : LSB-justified store data
// - be/wdata : byte enables and lane-shifted store data for this beat
// - rdata    : bus read data for this beat
// - asm_q    : assembly register contents before this beat
// - asm_d    : assembly register value after merging this beat
// - ld_data  : assembly register extended to 32 bits per size code
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int BUS_W = 32,
  localparam int BYTES = BUS_W / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic             beat,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       size,
  input  logic [31:0]      st_data,
  output logic [BYTES-1:0] be,
  output logic [BUS_W-1:0] wdata,
  input  logic [BUS_W-1:0] rdata,
  input  logic [31:0]      asm_q,
  output logic [31:0]      asm_d,
  output logic [31:0]      ld_data
);

  logic [2:0]         nb;
  logic [3:0]         nb_mask;
  logic [31:0]        st_masked;
  logic [2*BUS_W-1:0] st_win;
  logic [2*BYTES-1:0] be_win;
  logic [2*BUS_W-1:0] ld_win;

  // The access is shifted into a two-word window: the low word is beat 0,
  // the high word is whatever spilled over into beat 1.
  // NOTE: every always_comb output gets a value on every path (here via the
  // case defaults); a missing assignment would infer a latch.
  always_comb begin
    nb = size_bytes(size);
    case (nb)
      3'd1:    nb_mask = 4'b0001;
      3'd2:    nb_mask = 4'b0011;
      default: nb_mask = 4'b1111;
    endcase
    // Bytes above the access size must not leak onto disabled lanes.
    st_masked = st_data & {{8{nb_mask[3]}}, {8{nb_mask[2]}}, {8{nb_mask[1]}}, {8{nb_mask[0]}}};
    st_win    = {{(2*BUS_W-32){1'b0}}, st_masked} << {off, 3'b000};
    be_win    = {{(2*BYTES-4){1'b0}}, nb_mask} << off;
    wdata     = beat ? st_win[2*BUS_W-1:BUS_W] : st_win[BUS_W-1:0];
    be        = beat ? be_win[2*BYTES-1:BYTES] : be_win[BYTES-1:0];

    // Place the beat in the same window, then shift the access down to bit 0.
    ld_win = beat ? {rdata, {BUS_W{1'b0}}} : {{BUS_W{1'b0}}, rdata};
    asm_d  = (beat ? asm_q : 32'd0) | 32'(ld_win >> {off, 3'b000});

    case (nb)
      3'd1:    ld_data = is_signed(size) ? {{24{asm_q[7]}}, asm_q[7:0]}
                                         : {24'd0, asm_q[7:0]};
      3'd2:    ld_data = is_signed(size) ? {{16{asm_q[15]}}, asm_q[15:0]}
                                         : {16'd0, asm_q[15:0]};
      default: ld_data = asm_q;
    endcase
  end

endmodule

// File: rtl/lsu_split_unit.sv
// Load/store unit between the core memory stage and the data-memory bus.
// Misaligned accesses that cross a bus word are split into two beats
// (MISALIGN_SPLIT=1) or rejected with lsu_misalign (MISALIGN_SPLIT=0).
// Ports:
// - clk, rstn              : clock, asynchronous active-low reset
// - lsu_req/we/size/addr/wdata : core request, held while lsu_stall_req=1
// - lsu_rdata              : extended load result, valid in the DONE cycle
// - lsu_stall_req          : pipeline freeze while the access is in flight
// - lsu_misalign           : rejected misaligned access (combinational)
// - mem_req/we/addr/be/wdata : bus request, held until mem_gnt
// - mem_gnt, mem_rvalid, mem_rdata : bus accept, response and read data
module lsu_split_unit
  import lsu_pkg::*;
#(
  parameter  int ADDR_W         = 32,
  parameter  int BUS_W          = 32,
  parameter  int MISALIGN_SPLIT = 1,
  localparam int BYTES          = BUS_W / 8,
  localparam int OFF_W          = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_size,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_stall_req,
  output logic              lsu_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTES-1:0]  mem_be,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BUS_W-1:0]  mem_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              split_q, split_d;
  logic              beat_q, beat_d;
  logic [31:0]       asm_q, asm_d;

  logic [OFF_W-1:0]  req_off;
  logic [2:0]        req_nb;
  logic              req_cross, req_unal, misalign_err;
  logic [ADDR_W-1:0] beat_addr;
  logic [BYTES-1:0]  lane_be;
  logic [BUS_W-1:0]  lane_wdata;
  logic [31:0]       lane_asm, lane_ld;

  lsu_lane_align #(.BUS_W(BUS_W)) u_lane (
    .beat   (beat_q),
    .off    (addr_q[OFF_W-1:0]),
    .size   (size_q),
    .st_data(wdata_q),
    .be     (lane_be),
    .wdata  (lane_wdata),
    .rdata  (mem_rdata),
    .asm_q  (asm_q),
    .asm_d  (lane_asm),
    .ld_data(lane_ld)
  );

  // Alignment check on the incoming request.
  always_comb begin
    req_off   = lsu_addr[OFF_W-1:0];
    req_nb    = size_bytes(lsu_size);
    req_cross = (int'(req_off) + int'(req_nb)) > BYTES;
    // nb-1 as a 2-bit mask: 4 -> 2'b11, 2 -> 2'b01, 1 -> 2'b00.
    req_unal  = (lsu_addr[1:0] & (req_nb[1:0] - 2'd1)) != 2'b00;
    misalign_err = (MISALIGN_SPLIT == 0) && (req_cross || req_unal);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    split_d = split_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    case (state_q)
      IDLE: begin
        if (lsu_req && !misalign_err) begin
          addr_d  = lsu_addr;
          size_d  = lsu_size;
          we_d    = lsu_we;
          wdata_d = lsu_wdata;
          split_d = req_cross;
          beat_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = RSP;
      end
      RSP: begin
        if (mem_rvalid) begin
          if (!we_q) asm_d = lane_asm;
          if (split_q && !beat_q) begin
            beat_d  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      // The request still visible in DONE is the access just finished.
      default: state_d = IDLE;
    endcase
  end

  // Beat 1 address wraps naturally at 2^ADDR_W.
  assign beat_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                   + (beat_q ? ADDR_W'(BYTES) : '0);

  assign mem_req       = (state_q == REQ);
  assign mem_we        = mem_req && we_q;
  assign mem_addr      = mem_req ? beat_addr : '0;
  assign mem_be        = mem_req ? lane_be : '0;
  assign mem_wdata     = mem_we ? lane_wdata : '0;
  assign lsu_misalign  = (state_q == IDLE) && lsu_req && misalign_err;
  assign lsu_stall_req = ((state_q == IDLE) && lsu_req && !misalign_err)
                       || (state_q == REQ) || (state_q == RSP);
  assign lsu_rdata     = ((state_q == DONE) && !we_q) ? lane_ld : 32'd0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      split_q <= 1'b0;
      beat_q  <= 1'b0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
    end
  end

endmodule
